// File: rtl/meta_arbiter.sv
// Round-robin arbiter forwarding one channel's meta + data packet at a time to a header inserter.
// Optional length check (keep-byte count vs. meta length -> len_err) under META_ARBITER_LEN_CHECK_EN.
module meta_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int TDATA_BYTES = 8,
  parameter int TKEEP_WIDTH = TDATA_BYTES,
  parameter int TID_WIDTH   = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_CH-1:0]                 req_meta_tvalid,
  output logic [NUM_CH-1:0]                 req_meta_tready,
  input  logic [16*NUM_CH-1:0]              req_meta_tdata,
  input  logic [NUM_CH-1:0]                 req_tvalid,
  output logic [NUM_CH-1:0]                 req_tready,
  input  logic [8*TDATA_BYTES*NUM_CH-1:0]   req_tdata,
  input  logic [TKEEP_WIDTH*NUM_CH-1:0]     req_tkeep,
  input  logic [NUM_CH-1:0]                 req_tlast,
  output logic                              meta_tvalid,
  input  logic                              meta_tready,
  output logic [15:0]                       meta_tdata,
  output logic [TID_WIDTH-1:0]              meta_tid,
  output logic                              data_tvalid,
  input  logic                              data_tready,
  output logic [8*TDATA_BYTES-1:0]          data_tdata,
  output logic [TKEEP_WIDTH-1:0]            data_tkeep,
  output logic                              data_tlast,
  output logic                              busy,
  output logic                              len_err
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = 8 * TDATA_BYTES;

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, last_grant, pick;
  logic          any_req, meta_hs, data_hs;

  // Descending scan so the lowest offset from last_grant+1 wins.
  always_comb begin
    pick    = last_grant;
    any_req = |req_meta_tvalid;
    for (int i = NUM_CH; i >= 1; i--) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_CH;
      if (req_meta_tvalid[idx]) pick = GW'(idx);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant      <= pick;
        last_grant <= pick;
      end
    end
  end

  assign meta_hs = (state == META) && meta_tvalid && meta_tready;
  assign data_hs = (state == DATA) && data_tvalid && data_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = META;
      META:    if (meta_hs) state_nxt = DATA;
      DATA:    if (data_hs && data_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_meta_tready = '0;
    req_tready      = '0;
    meta_tvalid     = 1'b0;
    data_tvalid     = 1'b0;
    busy            = (state != IDLE);
    meta_tdata      = req_meta_tdata[16*grant +: 16];
    meta_tid        = TID_WIDTH'(grant);
    data_tdata      = req_tdata[DW*grant +: DW];
    data_tkeep      = req_tkeep[TKEEP_WIDTH*grant +: TKEEP_WIDTH];
    data_tlast      = req_tlast[grant];
    case (state)
      META: begin
        meta_tvalid            = req_meta_tvalid[grant];
        req_meta_tready[grant] = meta_tready;
      end
      DATA: begin
        data_tvalid       = req_tvalid[grant];
        req_tready[grant] = data_tready;
      end
      default: ;
    endcase
  end

`ifdef META_ARBITER_LEN_CHECK_EN
  logic [15:0] exp_len, byte_cnt, beat_bytes, byte_sum;

  always_comb begin
    beat_bytes = '0;
    for (int k = 0; k < TKEEP_WIDTH; k++) beat_bytes = beat_bytes + 16'(data_tkeep[k]);
  end

  assign byte_sum = byte_cnt + beat_bytes;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      exp_len  <= '0;
      byte_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (meta_hs) begin
        exp_len  <= meta_tdata;
        byte_cnt <= '0;
      end
      if (data_hs) begin
        byte_cnt <= byte_sum;
        if (data_tlast) len_err <= (byte_sum != exp_len);
      end
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_meta_arbiter.sv
// Directed bench for meta_arbiter: cycle table for rotation/stall cases plus hand sequences.
module tb_meta_arbiter;
  localparam int NCH = 4;
  localparam int TB  = 8;
  localparam int DW  = 8 * TB;

  logic              aclk, areset;
  logic [NCH-1:0]    req_meta_tvalid, req_meta_tready;
  logic [16*NCH-1:0] req_meta_tdata;
  logic [NCH-1:0]    req_tvalid, req_tready;
  logic [DW*NCH-1:0] req_tdata;
  logic [TB*NCH-1:0] req_tkeep;
  logic [NCH-1:0]    req_tlast;
  logic              meta_tvalid, meta_tready;
  logic [15:0]       meta_tdata;
  logic [3:0]        meta_tid;
  logic              data_tvalid, data_tready;
  logic [DW-1:0]     data_tdata;
  logic [TB-1:0]     data_tkeep;
  logic              data_tlast, busy, len_err;

  meta_arbiter #(.NUM_CH(NCH), .TDATA_BYTES(TB), .TKEEP_WIDTH(TB), .TID_WIDTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .req_meta_tvalid(req_meta_tvalid), .req_meta_tready(req_meta_tready), .req_meta_tdata(req_meta_tdata),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tlast(req_tlast),
    .meta_tvalid(meta_tvalid), .meta_tready(meta_tready), .meta_tdata(meta_tdata), .meta_tid(meta_tid),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .data_tkeep(data_tkeep), .data_tlast(data_tlast), .busy(busy), .len_err(len_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit         rst;
    logic [3:0] mv, dv, dl;
    logic       mr, dr;
    logic       ebusy, emv, edv;
    logic [3:0] ermr, erdr, etid;
  } vec_t;
  vec_t tbl[$];

  logic [63:0] out_q[$];

  // Beats accepted downstream, sampled just before the rising edge.
  always begin
    @(negedge aclk);
    #4;
    if (!areset && data_tvalid && data_tready) out_q.push_back(data_tdata);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ch_pat(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {8{b}};
  endfunction

  function automatic logic [63:0] beat_pat(input int ch, input int b);
    return {8'(ch), 40'h0, 16'(b)};
  endfunction

  task automatic init_channels();
    for (int i = 0; i < NCH; i++) begin
      req_meta_tdata[16*i +: 16] = 16'h0100 + 16'(i);
      req_tdata[DW*i +: DW]      = ch_pat(i);
      req_tkeep[TB*i +: TB]      = 8'hFF;
    end
  endtask

  task automatic do_reset();
    areset          = 1'b1;
    req_meta_tvalid = '0;
    req_tvalid      = '0;
    req_tlast       = '0;
    meta_tready     = 1'b0;
    data_tready     = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic add_v(input bit rst, input logic [3:0] mv, dv, dl, input logic mr, dr,
                       input logic ebusy, emv, edv, input logic [3:0] ermr, erdr, etid);
    vec_t v;
    v.rst = rst; v.mv = mv; v.dv = dv; v.dl = dl; v.mr = mr; v.dr = dr;
    v.ebusy = ebusy; v.emv = emv; v.edv = edv; v.ermr = ermr; v.erdr = erdr; v.etid = etid;
    tbl.push_back(v);
  endtask

  task automatic put_beat(input int ch, input int b, input int nb, input logic [7:0] klast);
    req_tvalid[ch]          = 1'b1;
    req_tdata[DW*ch +: DW]  = beat_pat(ch, b);
    req_tkeep[TB*ch +: TB]  = (b == nb - 1) ? klast : 8'hFF;
    req_tlast[ch]           = (b == nb - 1);
  endtask

  // Single-requester packet with both sinks always ready; counts cycles with len_err high.
  task automatic send_pkt(input int ch, input logic [15:0] len, input int nb,
                          input logic [7:0] klast, output int errs);
    errs = 0;
    req_meta_tdata[16*ch +: 16] = len;
    @(negedge aclk);
    req_meta_tvalid[ch] = 1'b1;
    put_beat(ch, 0, nb, klast);
    #1 errs += int'(len_err);
    @(negedge aclk);
    #1 errs += int'(len_err);
    for (int b = 0; b < nb; b++) begin
      @(negedge aclk);
      req_meta_tvalid[ch] = 1'b0;
      put_beat(ch, b, nb, klast);
      #1 errs += int'(len_err);
    end
    repeat (3) begin
      @(negedge aclk);
      req_tvalid[ch] = 1'b0;
      req_tlast[ch]  = 1'b0;
      #1 errs += int'(len_err);
    end
  endtask

  initial begin
    int errs;
    int exp_err;
    areset = 1'b1;
    req_meta_tvalid = '0; req_tvalid = '0; req_tlast = '0;
    req_meta_tdata = '0; req_tdata = '0; req_tkeep = '0;
    meta_tready = 1'b0; data_tready = 1'b0;
    init_channels();

    // All four channels requesting one-beat packets: IDLE/META/DATA per packet, grants 0,1,2,3,0,1.
    for (int k = 0; k < 18; k++) begin
      int ph, g;
      ph = k % 3;
      g  = (k / 3) % 4;
      add_v(k == 0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1,
            ph != 0, ph == 1, ph == 2,
            (ph == 1) ? 4'(1 << g) : 4'h0, (ph == 2) ? 4'(1 << g) : 4'h0, 4'(g));
    end
    // Channel 3 data waits while channel 0 holds the grant and until its own meta completes.
    add_v(1, 4'b0001, 4'b1000, 4'b1000, 1, 1,  0, 0, 0, 4'b0000, 4'b0000, 4'd0);
    add_v(0, 4'b0001, 4'b1000, 4'b1000, 1, 1,  1, 1, 0, 4'b0001, 4'b0000, 4'd0);
    add_v(0, 4'b1000, 4'b1001, 4'b1000, 1, 1,  1, 0, 1, 4'b0000, 4'b0001, 4'd0);
    add_v(0, 4'b1000, 4'b1001, 4'b1001, 1, 1,  1, 0, 1, 4'b0000, 4'b0001, 4'd0);
    add_v(0, 4'b1000, 4'b1000, 4'b1000, 1, 1,  0, 0, 0, 4'b0000, 4'b0000, 4'd0);
    add_v(0, 4'b1000, 4'b1000, 4'b1000, 0, 1,  1, 1, 0, 4'b0000, 4'b0000, 4'd3);
    add_v(0, 4'b1000, 4'b1000, 4'b1000, 1, 1,  1, 1, 0, 4'b1000, 4'b0000, 4'd3);
    add_v(0, 4'b1000, 4'b1000, 4'b1000, 1, 1,  1, 0, 1, 4'b0000, 4'b1000, 4'd3);
    add_v(0, 4'b0000, 4'b0000, 4'b0000, 1, 1,  0, 0, 0, 4'b0000, 4'b0000, 4'd3);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge aclk);
      req_meta_tvalid = tbl[i].mv;
      req_tvalid      = tbl[i].dv;
      req_tlast       = tbl[i].dl;
      meta_tready     = tbl[i].mr;
      data_tready     = tbl[i].dr;
      #1;
      check($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].ebusy));
      check($sformatf("v%0d meta_tvalid", i), 64'(meta_tvalid), 64'(tbl[i].emv));
      check($sformatf("v%0d data_tvalid", i), 64'(data_tvalid), 64'(tbl[i].edv));
      check($sformatf("v%0d req_meta_tready", i), 64'(req_meta_tready), 64'(tbl[i].ermr));
      check($sformatf("v%0d req_tready", i), 64'(req_tready), 64'(tbl[i].erdr));
      if (tbl[i].ebusy) check($sformatf("v%0d meta_tid", i), 64'(meta_tid), 64'(tbl[i].etid));
      if (tbl[i].emv)
        check($sformatf("v%0d meta_tdata", i), 64'(meta_tdata), 64'(16'h0100 + 16'(tbl[i].etid)));
      if (tbl[i].edv) begin
        check($sformatf("v%0d data_tdata", i), data_tdata, ch_pat(int'(tbl[i].etid)));
        check($sformatf("v%0d data_tlast", i), 64'(data_tlast), 64'(tbl[i].dl[tbl[i].etid]));
      end
    end

    // Channel 2: meta 16, two full beats.
    do_reset();
    out_q.delete();
    req_meta_tdata[32 +: 16] = 16'd16;
    @(negedge aclk);
    meta_tready = 1'b1; data_tready = 1'b1;
    req_meta_tvalid = 4'b0100;
    put_beat(2, 0, 2, 8'hFF);
    #1 check("c2 idle req_tready", 64'(req_tready), 64'h0);
    @(negedge aclk);
    #1;
    check("c2 meta_tvalid", 64'(meta_tvalid), 64'h1);
    check("c2 meta_tid", 64'(meta_tid), 64'd2);
    check("c2 meta_tdata", 64'(meta_tdata), 64'd16);
    check("c2 req_meta_tready", 64'(req_meta_tready), 64'b0100);
    check("c2 meta req_tready", 64'(req_tready), 64'h0);
    @(negedge aclk);
    req_meta_tvalid = '0;
    #1;
    check("c2 beat1 data", data_tdata, beat_pat(2, 0));
    check("c2 beat1 last", 64'(data_tlast), 64'h0);
    check("c2 beat1 req_tready", 64'(req_tready), 64'b0100);
    @(negedge aclk);
    put_beat(2, 1, 2, 8'hFF);
    #1;
    check("c2 beat2 data", data_tdata, beat_pat(2, 1));
    check("c2 beat2 last", 64'(data_tlast), 64'h1);
    @(negedge aclk);
    req_tvalid = '0; req_tlast = '0;
    #1;
    check("c2 busy after", 64'(busy), 64'h0);
    check("c2 len_err", 64'(len_err), 64'h0);
    check("c2 beat count", 64'(out_q.size()), 64'd2);
    if (out_q.size() == 2) begin
      check("c2 q0", out_q[0], beat_pat(2, 0));
      check("c2 q1", out_q[1], beat_pat(2, 1));
    end

    // Channel 1: three beats, sink stalls five cycles on beat 2.
    do_reset();
    out_q.delete();
    req_meta_tdata[16 +: 16] = 16'd24;
    @(negedge aclk);
    meta_tready = 1'b1; data_tready = 1'b1;
    req_meta_tvalid = 4'b0010;
    put_beat(1, 0, 3, 8'hFF);
    @(negedge aclk);
    #1 check("stall meta_tid", 64'(meta_tid), 64'd1);
    @(negedge aclk);
    req_meta_tvalid = '0;
    #1 check("stall beat1 data", data_tdata, beat_pat(1, 0));
    @(negedge aclk);
    put_beat(1, 1, 3, 8'hFF);
    data_tready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("stall%0d data_tvalid", s), 64'(data_tvalid), 64'h1);
      check($sformatf("stall%0d data_tdata", s), data_tdata, beat_pat(1, 1));
      check($sformatf("stall%0d req_tready", s), 64'(req_tready), 64'h0);
      @(negedge aclk);
    end
    data_tready = 1'b1;
    #1 check("stall release req_tready", 64'(req_tready), 64'b0010);
    @(negedge aclk);
    put_beat(1, 2, 3, 8'hFF);
    #1 check("stall beat3 last", 64'(data_tlast), 64'h1);
    @(negedge aclk);
    req_tvalid = '0; req_tlast = '0;
    #1 check("stall busy after", 64'(busy), 64'h0);
    check("stall beat count", 64'(out_q.size()), 64'd3);
    for (int b = 0; b < 3 && b < out_q.size(); b++)
      check($sformatf("stall q%0d", b), out_q[b], beat_pat(1, b));

    // Length check: 8+8+4 = 20 matches, 8+8+2 = 18 does not.
`ifdef META_ARBITER_LEN_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset();
    meta_tready = 1'b1; data_tready = 1'b1;
    out_q.delete();
    send_pkt(0, 16'd20, 3, 8'h0F, errs);
    check("len good err cycles", 64'(errs), 64'd0);
    check("len good beats", 64'(out_q.size()), 64'd3);
    send_pkt(0, 16'd20, 3, 8'h03, errs);
    check("len bad err cycles", 64'(errs), 64'(exp_err));
    check("len bad busy after", 64'(busy), 64'h0);

    // Reset during beat 2 of a 4-beat packet on channel 1; channel 0 must win afterwards.
    do_reset();
    out_q.delete();
    req_meta_tdata[16 +: 16] = 16'd32;
    @(negedge aclk);
    meta_tready = 1'b1; data_tready = 1'b1;
    req_meta_tvalid = 4'b0010;
    put_beat(1, 0, 4, 8'hFF);
    @(negedge aclk);
    @(negedge aclk);
    req_meta_tvalid = '0;
    @(negedge aclk);
    put_beat(1, 1, 4, 8'hFF);
    req_meta_tvalid = 4'b0001;
    areset = 1'b1;
    #1;
    check("rst meta_tvalid", 64'(meta_tvalid), 64'h0);
    check("rst data_tvalid", 64'(data_tvalid), 64'h0);
    check("rst req_meta_tready", 64'(req_meta_tready), 64'h0);
    check("rst req_tready", 64'(req_tready), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst len_err", 64'(len_err), 64'h0);
    @(negedge aclk);
    req_meta_tvalid = 4'b0011;
    #1 check("rst hold req_tready", 64'(req_tready), 64'h0);
    areset = 1'b0;
    #1;
    check("post idle busy", 64'(busy), 64'h0);
    check("post idle req_tready", 64'(req_tready), 64'h0);
    @(negedge aclk);
    #1;
    check("post meta_tvalid", 64'(meta_tvalid), 64'h1);
    check("post meta_tid", 64'(meta_tid), 64'd0);
    check("post req_tready", 64'(req_tready), 64'h0);
    check("post beats consumed", 64'(out_q.size()), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/meta_arbiter.md
META_ARBITER -- requirements
Module: meta_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter TDATA_BYTES, default 8, data bus width in bytes.
REQ-003 SHALL have parameter TKEEP_WIDTH, default TDATA_BYTES, keep width.
REQ-004 SHALL have parameter TID_WIDTH, default 4, output tid width, at least clog2(NUM_CH).
REQ-005 SHALL have ports:
- aclk  in  1  single clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- req_meta_tvalid / req_meta_tready  in / out  NUM_CH  per-channel meta handshake.
- req_meta_tdata  in  16*NUM_CH  per-channel payload byte length; channel i at [16i+15:16i].
- req_tvalid / req_tready  in / out  NUM_CH  per-channel data handshake.
- req_tdata  in  8*TDATA_BYTES*NUM_CH  per-channel data, packed like req_meta_tdata.
- req_tkeep  in  TKEEP_WIDTH*NUM_CH  per-channel keep, packed.
- req_tlast  in  NUM_CH  per-channel last.
- meta_tvalid / meta_tready  out / in  1  meta to the header inserter.
- meta_tdata  out  16  granted length.
- meta_tid  out  TID_WIDTH  granted channel index, zero-extended.
- data_tvalid / data_tready  out / in  1  data to the header inserter.
- data_tdata / data_tkeep / data_tlast  out  8*TDATA_BYTES / TKEEP_WIDTH / 1  granted channel data.
- busy  out  1  high in every state except IDLE.
- len_err  out  1  one-cycle length-mismatch pulse (REQ-016).

Function
REQ-006 SHALL implement states IDLE, META and DATA.
REQ-007 IDLE: when any req_meta_tvalid is high, SHALL register grant as the first asserted channel searching upward from last_grant+1 modulo NUM_CH, set last_grant to it, and enter META on the next edge; grant latency is one cycle.
REQ-008 META: meta_tvalid SHALL equal req_meta_tvalid[grant]; meta_tdata and meta_tid SHALL follow the granted channel; req_meta_tready[grant] SHALL equal meta_tready.
REQ-009 On the META handshake, SHALL latch meta_tdata as exp_len, clear the byte counter, and enter DATA.
REQ-010 DATA: data outputs SHALL combinationally follow the granted channel; req_tready[grant] SHALL equal data_tready.
REQ-011 On a DATA handshake with tlast high, SHALL return to IDLE on the next edge; no two packets ever interleave.
REQ-012 All readies of non-granted channels, and all readies in IDLE, SHALL be 0; meta_tvalid is 0 outside META and data_tvalid is 0 outside DATA.
REQ-013 Data presented by a channel before its meta handshake SHALL be stalled (tready 0), never dropped.
REQ-014 Requests arriving while a channel is granted SHALL wait; requesters are never starved; with all channels requesting, grants rotate 0,1,...,NUM_CH-1,0.
REQ-015 IDLE to grant to IDLE SHALL cost exactly one idle cycle between packets.

Reset
REQ-017 On areset, SHALL immediately enter IDLE, set last_grant to NUM_CH-1 (channel 0 first), and clear exp_len, the counter and len_err.
REQ-018 During reset, all tvalid/tready outputs, busy and len_err SHALL be 0.
REQ-019 After a reset asserted mid-packet, the remainder of the aborted packet SHALL be treated as new traffic and SHALL not be consumed until its channel is granted.

Configuration
REQ-016 With macro META_ARBITER_LEN_CHECK_EN defined:
- the counter SHALL add popcount(tkeep) on each DATA handshake, 16-bit wrapping.
- on the tlast handshake, the sum including that beat SHALL be compared with exp_len modulo 2^16; on mismatch len_err pulses high the following cycle.
- flow control SHALL be unaffected.
REQ-020 Without META_ARBITER_LEN_CHECK_EN, SHALL omit the counter and comparator, and len_err SHALL be tied to 0.

Verification
REQ-021 Channel 2 only: meta 16 with two beats of keep 0xFF, tlast on beat 2 -> meta_tid=2, meta_tdata=16, both beats forwarded in order, len_err=0, IDLE afterwards.
REQ-022 All 4 channels requesting continuously, one-beat packets -> grant order 0,1,2,3,0,1 with exactly one idle cycle between packets.
REQ-023 data_tready low for 5 cycles mid-packet on channel 1 -> outputs held stable, req_tready[1]=0 throughout, no beat lost or duplicated.
REQ-024 Channel 3 drives data before meta while channel 0 is granted -> req_tready[3]=0 until channel 3's meta handshake completes.
REQ-025 LEN_CHECK_EN set, meta 20, beats with keep 0xFF then 0x0F -> len_err=0; a second packet with meta 20 but keep 0xFF then 0x03 -> len_err pulses once.
REQ-026 areset pulsed during beat 2 of a 4-beat packet on channel 1 -> all readies and valids 0, busy=0; after release, channel 0 (requesting) is granted before channel 1.
